prog_instr_mem: RTL and testbench

Parametrised, writable instruction memory for the microprocessor datapath. It replaces a hard-wired ROM with a register-file store. A built-in default program is restored on reset. A single-cycle registered fetch port feeds the decode stage. A streaming load port lets a host (UART or testbench) overwrite the program at run time. A small state machine arbitrates between fetch and load.

---
 rtl/prog_instr_mem_if.sv | 32 +++
 rtl/prog_instr_mem.sv | 137 +++++++++++++
 tb/tb_prog_instr_mem.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/prog_instr_mem_if.sv
// Fetch and program-load bus of the writable instruction memory.
// master = host/decode side, slave = prog_instr_mem.
interface prog_instr_mem_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_busy;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
    logic              parity_err;

    modport master (
        output fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
        input  instruction, instr_valid, load_ready, load_busy, load_done,
               load_count, parity_err
    );

    modport slave (
        input  fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
        output instruction, instr_valid, load_ready, load_busy, load_done,
               load_count, parity_err
    );
endinterface

// File: rtl/prog_instr_mem.sv
// Writable instruction memory: boot program restored on reset, 1-cycle registered
// fetch port, streaming load port. Optional even-parity per word via IMEM_PARITY_EN.
module prog_instr_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    prog_instr_mem_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] instruction_q;
    logic              instr_valid_q;
    logic              load_ready_q;
    logic              load_busy_q;
    logic              load_done_q;
    logic [ADDR_W:0]   load_count_q;

    logic              wr_en_c;
    logic              last_beat_c;
    logic              fetch_hit_c;
    logic              in_range_c;
    logic [DATA_W-1:0] rd_word_c;

    function automatic logic [DATA_W-1:0] boot_word(input int unsigned idx);
        case (idx)
            0:       return DATA_W'(8'h49);
            1:       return DATA_W'(8'hC1);
            2:       return DATA_W'(8'h18);
            3:       return DATA_W'(8'hA9);
            4:       return DATA_W'(8'h4D);
            default: return '0;
        endcase
    endfunction

    // Next-state and write strobes; fetch is only serviced while idle
    always_comb begin
        state_d     = state_q;
        wr_en_c     = 1'b0;
        last_beat_c = 1'b0;
        fetch_hit_c = (state_q == S_IDLE) && bus.fetch_en;
        in_range_c  = {1'b0, bus.fetch_addr} < DEPTH_L;
        rd_word_c   = mem_q[bus.fetch_addr[IDX_W-1:0]];
        case (state_q)
            S_IDLE: begin
                if (bus.load_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (bus.load_valid) begin
                    wr_en_c = 1'b1;
                    if (bus.load_last || (ptr_q == PTR_LAST)) begin
                        last_beat_c = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control, pointer and fetch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            load_ready_q  <= 1'b0;
            load_busy_q   <= 1'b0;
            load_done_q   <= 1'b0;
            load_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            load_ready_q <= (state_d == S_LOAD);
            load_busy_q  <= (state_d != S_IDLE);
            load_done_q  <= (state_d == S_DONE);
            if ((state_q == S_IDLE) && bus.load_start) ptr_q <= '0;
            else if (wr_en_c)                          ptr_q <= ptr_q + ADDR_W'(1);
            if (last_beat_c) load_count_q <= (ADDR_W+1)'(ptr_q) + (ADDR_W+1)'(1);
            instr_valid_q <= fetch_hit_c;
            if (fetch_hit_c) instruction_q <= in_range_c ? rd_word_c : '0;
        end
    end

    // Program store; reset restores the boot program and discards a partial load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= boot_word(i);
        end else if (wr_en_c) begin
            mem_q[ptr_q[IDX_W-1:0]] <= bus.load_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic             parity_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) par_q[i] <= ^boot_word(i);
            parity_err_q <= 1'b0;
        end else begin
            if (wr_en_c) par_q[ptr_q[IDX_W-1:0]] <= ^bus.load_data;
            if (fetch_hit_c)
                parity_err_q <= in_range_c &&
                                ((^rd_word_c) != par_q[bus.fetch_addr[IDX_W-1:0]]);
            else if (state_q != S_IDLE)
                parity_err_q <= 1'b0;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.instruction = instruction_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.load_ready  = load_ready_q;
    assign bus.load_busy   = load_busy_q;
    assign bus.load_done   = load_done_q;
    assign bus.load_count  = load_count_q;

endmodule

// File: tb/tb_prog_instr_mem.sv
// Scoreboard bench for prog_instr_mem: fetch expectations are queued as stimulus is
// driven and popped when the registered fetch port responds one cycle later.
module tb_prog_instr_mem;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 8;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              p;
    } exp_t;

    exp_t exp_q[$];

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic perr_exp = 1'b0;
    logic [DATA_W-1:0] model [DEPTH];

    prog_instr_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    prog_instr_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        model[0] = 8'h49; model[1] = 8'hC1; model[2] = 8'h18;
        model[3] = 8'hA9; model[4] = 8'h4D;
    endtask

    // One clock: drive inputs, queue the expected fetch response, then compare it.
    task automatic cyc(input logic fe, input logic [ADDR_W-1:0] fa, input logic ls,
                       input logic lv, input logic [DATA_W-1:0] ld, input logic ll,
                       input logic served);
        exp_t e;
        bus.fetch_en   = fe;
        bus.fetch_addr = fa;
        bus.load_start = ls;
        bus.load_valid = lv;
        bus.load_data  = ld;
        bus.load_last  = ll;
        e.v = served;
        e.d = '0;
        if (int'(fa) < int'(DEPTH)) e.d = model[int'(fa)];
        e.p = perr_exp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("instr_valid", 32'(bus.instr_valid), 32'(e.v));
        if (e.v) begin
            check_eq("instruction", 32'(bus.instruction), 32'(e.d));
            check_eq("parity_err", 32'(bus.parity_err), 32'(e.p));
        end
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] fa);
        cyc(1'b1, fa, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        bus.fetch_en = 1'b0; bus.fetch_addr = '0; bus.load_start = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_instruction", 32'(bus.instruction), 32'h0);
        check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        check_eq("rst_load_ready",  32'(bus.load_ready),  32'h0);
        check_eq("rst_load_busy",   32'(bus.load_busy),   32'h0);
        check_eq("rst_load_done",   32'(bus.load_done),   32'h0);
        check_eq("rst_load_count",  32'(bus.load_count),  32'h0);
        check_eq("rst_parity_err",  32'(bus.parity_err),  32'h0);
        reset = 1'b0;

        // Boot program, last word, out-of-range NOP
        for (int a = 0; a < 5; a++) fetch(ADDR_W'(a));
        fetch(ADDR_W'(31));
        fetch(ADDR_W'(40));
        idle();
        check_eq("hold_instruction", 32'(bus.instruction), 32'h0);

        // Short load of three words
        cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        check_eq("short_ready", 32'(bus.load_ready), 32'h1);
        check_eq("short_busy",  32'(bus.load_busy),  32'h1);
        cyc(1'b0, '0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
        check_eq("last_no_valid_ready", 32'(bus.load_ready), 32'h1);
        check_eq("last_no_valid_done",  32'(bus.load_done),  32'h0);
        model[0] = 8'h11; cyc(1'b0, '0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        model[1] = 8'h22; cyc(1'b0, '0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        check_eq("short_ready_mid", 32'(bus.load_ready), 32'h1);
        model[2] = 8'h33; cyc(1'b0, '0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        check_eq("short_done",  32'(bus.load_done),  32'h1);
        check_eq("short_count", 32'(bus.load_count), 32'd3);
        check_eq("short_ready_done", 32'(bus.load_ready), 32'h0);
        check_eq("short_busy_done",  32'(bus.load_busy),  32'h1);
        idle();
        check_eq("short_done_clear", 32'(bus.load_done), 32'h0);
        check_eq("short_busy_clear", 32'(bus.load_busy), 32'h0);
        for (int a = 0; a < 4; a++) fetch(ADDR_W'(a));

        // Full load with fetch_en held high; the start cycle's fetch is still serviced
        cyc(1'b1, ADDR_W'(4), 1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            d = DATA_W'(i * 7 + 3);
            model[i] = d;
            cyc(1'b1, ADDR_W'(0), 1'b0, 1'b1, d, 1'b0, 1'b0);
            if (i < int'(DEPTH) - 1) begin
                check_eq("full_ready", 32'(bus.load_ready), 32'h1);
            end else begin
                check_eq("full_done",  32'(bus.load_done),  32'h1);
                check_eq("full_ready_done", 32'(bus.load_ready), 32'h0);
                check_eq("full_count", 32'(bus.load_count), 32'd32);
            end
        end
        cyc(1'b1, ADDR_W'(0), 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
        check_eq("extra_beat_busy", 32'(bus.load_busy), 32'h0);
        check_eq("extra_beat_done", 32'(bus.load_done), 32'h0);
        fetch(ADDR_W'(0));
        fetch(ADDR_W'(31));
        fetch(ADDR_W'(1));
        fetch(ADDR_W'(5));

        // Reset in the middle of a load
        cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("midrst_busy",  32'(bus.load_busy),  32'h0);
        check_eq("midrst_ready", 32'(bus.load_ready), 32'h0);
        model_reset();
        idle();
        idle();
        reset = 1'b0;
        fetch(ADDR_W'(0));
        fetch(ADDR_W'(1));
        fetch(ADDR_W'(2));

`ifdef IMEM_PARITY_EN
        // Corrupt the stored parity of word 2 so it disagrees with its data
        force dut.par_q[2] = ~(^model[2]);
        perr_exp = 1'b1;
        fetch(ADDR_W'(2));
        perr_exp = 1'b0;
        release dut.par_q[2];
`endif

        if (exp_q.size() != 0) check_eq("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
